// File: rtl/nios2_ocimem_ctrl.sv
// nios2_ocimem_ctrl: JTAG/CPU arbitrated access to the Nios II on-chip debug monitor RAM.
// Latency: JTAG op done (monitor_ready) 2 cycles after its strobe when uncontended; CPU read data 1 cycle after acceptance.
// Backpressure: CPU wins the RAM port; a JTAG op losing STARVE_MAX cycles stalls the CPU for one cycle via avs_waitrequest.
// Optional: define OCIMEM_PARITY_EN to store one even-parity bit per byte and flag JTAG read mismatches.
module nios2_ocimem_ctrl #(
  parameter int MEM_WORDS  = 256,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W:0]  WORDS_L  = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [CNT_W-1:0] STARVE_L = CNT_W'(STARVE_MAX);
`ifdef OCIMEM_PARITY_EN
  localparam int RAM_W = 36;
`else
  localparam int RAM_W = 32;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RD_WAIT, S_WR_DONE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              cpu_rd_q, cpu_rd_d;

  logic [RAM_W-1:0]  mem_q [MEM_WORDS];
  logic [RAM_W-1:0]  ram_q;

  logic              cpu_req, cpu_in_range, jtag_in_range;
  logic              jtag_needs_ram, force_jtag, jtag_go, cpu_go;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              par_err;
  logic              any_strobe;
  logic              unused_jdo;

  // jdo carries fields this block does not consume.
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Port arbitration: CPU first, JTAG forced through once the starve count hits its limit.
  always_comb begin
    cpu_req        = avs_read | avs_write;
    cpu_in_range   = {1'b0, avs_address} < WORDS_L;
    jtag_in_range  = {1'b0, maddr_q} < WORDS_L;
    jtag_needs_ram = (state_q == S_PEND) && (op_q != OP_NOP) && jtag_in_range;
    force_jtag     = jtag_needs_ram && (starve_q == STARVE_L);
    jtag_go        = jtag_needs_ram && (!cpu_req || force_jtag);
    cpu_go         = cpu_req && !force_jtag;

    ram_idx   = jtag_go ? maddr_q[IDX_W-1:0] : avs_address[IDX_W-1:0];
    ram_wdata = jtag_go ? wdata_q : avs_writedata;
    ram_be    = jtag_go ? 4'hF : avs_byteenable;
    // Gate with reset so a write still pending when reset lands is never performed.
    ram_we    = !reset && ((jtag_go && (op_q == OP_WR)) ||
                           (cpu_go && avs_write && cpu_in_range));
    ram_re    = !reset && ((jtag_go && (op_q == OP_RD)) ||
                           (cpu_go && avs_read && cpu_in_range));
    cpu_rd_d  = cpu_go && avs_read && cpu_in_range;
  end

  // Single-port RAM with byte-lane writes and a registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
`ifdef OCIMEM_PARITY_EN
          mem_q[ram_idx][32+i] <= ^ram_wdata[8*i +: 8];
`endif
        end
      end
    end
    if (ram_re) begin
      ram_q <= mem_q[ram_idx];
    end
  end

  // Parity check of the word just read for JTAG.
  always_comb begin
    par_err = 1'b0;
`ifdef OCIMEM_PARITY_EN
    for (int i = 0; i < 4; i++) begin
      if ((^ram_q[8*i +: 8]) != ram_q[32+i]) par_err = 1'b1;
    end
`endif
  end

  // JTAG op FSM: next state, address/data latching, ready and sticky error.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    maddr_d    = maddr_q;
    starve_d   = starve_q;
    mondreg_d  = mondreg_q;
    ready_d    = ready_q;
    error_d    = error_q;
    any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          op_d    = OP_WR;
          wdata_d = jdo[34:3];
        end else if (take_action_ocimem_a) begin
          maddr_d = jdo[17 +: ADDR_W];
          op_d    = jdo[34] ? OP_RD : OP_NOP;
          error_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          maddr_d = maddr_q + 1'b1;
          op_d    = OP_RD;
        end
        if (any_strobe) begin
          ready_d  = 1'b0;
          starve_d = '0;
          state_d  = S_PEND;
        end
        // Strobes that lose the same-cycle priority contest are reported, not executed.
        if ((take_action_ocimem_b && (take_action_ocimem_a || take_no_action_ocimem_a)) ||
            (take_action_ocimem_a && take_no_action_ocimem_a)) begin
          error_d = 1'b1;
        end
      end
      S_PEND: begin
        if (op_q == OP_NOP) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (!jtag_in_range || jtag_go) begin
          starve_d = '0;
          state_d  = (op_q == OP_RD) ? S_RD_WAIT : S_WR_DONE;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      S_RD_WAIT: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
        if (!jtag_in_range) begin
          error_d = 1'b1;
        end else begin
          mondreg_d = ram_q[31:0];
          if (par_err) error_d = 1'b1;
        end
      end
      S_WR_DONE: begin
        ready_d = 1'b1;
        maddr_d = maddr_q + 1'b1;
        state_d = S_IDLE;
        if (!jtag_in_range) error_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && any_strobe) error_d = 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      wdata_q   <= '0;
      maddr_q   <= '0;
      starve_q  <= '0;
      mondreg_q <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      cpu_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      maddr_q   <= maddr_d;
      starve_q  <= starve_d;
      mondreg_q <= mondreg_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      cpu_rd_q  <= cpu_rd_d;
    end
  end

  assign avs_readdata    = cpu_rd_q ? ram_q[31:0] : 32'h0;
  assign avs_waitrequest = force_jtag;
  assign MonDReg         = mondreg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// Directed bench for nios2_ocimem_ctrl: CPU/JTAG reads and writes, address wrap,
// out-of-range handling, starvation release, busy drops, reset abandon, strobe conflicts.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_nios2_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        tk_a = 1'b0;
  logic        tk_na = 1'b0;
  logic        tk_b = 1'b0;
  logic [8:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios2_ocimem_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (tk_a),
    .take_no_action_ocimem_a (tk_na),
    .take_action_ocimem_b    (tk_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic strobe_a(input logic [8:0] a, input logic rd);
    jdo = '0;
    jdo[25:17] = a;
    jdo[34] = rd;
    tk_a = 1'b1;
    step();
    tk_a = 1'b0;
  endtask

  task automatic strobe_na();
    tk_na = 1'b1;
    step();
    tk_na = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    tk_b = 1'b1;
    step();
    tk_b = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    step();
    avs_write      = 1'b0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    step();
    avs_read    = 1'b0;
    chk(tag, avs_readdata, exp);
  endtask

  initial begin
    // Reset values
    step(); step(); step();
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", monitor_ready, 32'h0);
    chk("rst_error", monitor_error, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", avs_waitrequest, 32'h0);
    reset = 1'b0;
    step();

    // CPU preload and byte-enable merge
    cpu_write(9'h010, 32'hDEADBEEF, 4'hF);
    cpu_write(9'h011, 32'hFFFFFFFF, 4'hF);
    cpu_write(9'h011, 32'h00000000, 4'b0101);
    cpu_write(9'h000, 32'h0BADF00D, 4'hF);
    cpu_write(9'h012, 32'h5A5A5A5A, 4'hF);
    cpu_read_chk("cpu_rd_0x10", 9'h010, 32'hDEADBEEF);
    cpu_read_chk("cpu_rd_byteen", 9'h011, 32'hFF00FF00);
    cpu_write(9'h100, 32'hFFFFFFFF, 4'hF);
    cpu_read_chk("cpu_rd_oor", 9'h100, 32'h0);
    cpu_read_chk("cpu_oor_wr_dropped", 9'h000, 32'h0BADF00D);

    // JTAG read of word 0x10, exact 2-cycle latency
    strobe_a(9'h010, 1'b1);
    step();
    chk("jrd_ready_t1", monitor_ready, 32'h0);
    step();
    chk("jrd_ready_t2", monitor_ready, 32'h1);
    chk("jrd_data", MonDReg, 32'hDEADBEEF);
    chk("jrd_error", monitor_error, 32'h0);

    // Address-only load, then JTAG write at 0x0FF
    strobe_a(9'h0FF, 1'b0);
    chk("ldonly_ready_clr", monitor_ready, 32'h0);
    step();
    chk("ldonly_ready", monitor_ready, 32'h1);
    chk("ldonly_MonDReg_hold", MonDReg, 32'hDEADBEEF);
    strobe_b(32'h12345678);
    step();
    chk("jwr_ready_t1", monitor_ready, 32'h0);
    step();
    chk("jwr_ready_t2", monitor_ready, 32'h1);
    chk("jwr_error", monitor_error, 32'h0);
    // Address advanced to 0x100: next write is out of range
    strobe_b(32'hAAAAAAAA);
    step(); step();
    chk("jwr_oor_error", monitor_error, 32'h1);
    chk("jwr_oor_ready", monitor_ready, 32'h1);
    strobe_a(9'h0FF, 1'b1);
    step(); step();
    chk("jrd_0xff", MonDReg, 32'h12345678);
    chk("err_cleared_by_a", monitor_error, 32'h0);
    cpu_read_chk("jwr_oor_no_alias", 9'h000, 32'h0BADF00D);

    // Out-of-range read at 0x1FF, then increment wraps to word 0
    strobe_a(9'h1FF, 1'b1);
    step(); step();
    chk("oor_rd_error", monitor_error, 32'h1);
    chk("oor_rd_ready", monitor_ready, 32'h1);
    chk("oor_rd_MonDReg_hold", MonDReg, 32'h12345678);
    strobe_na();
    step(); step();
    chk("wrap_rd_data", MonDReg, 32'h0BADF00D);
    chk("wrap_rd_ready", monitor_ready, 32'h1);
    chk("wrap_error_sticky", monitor_error, 32'h1);

    // CPU reads every cycle while a JTAG read of 0x11 is pending
    avs_address = 9'h010;
    avs_read    = 1'b1;
    strobe_a(9'h011, 1'b1);
    chk("cont_cpu_rdata", avs_readdata, 32'hDEADBEEF);
    chk("cont_waitreq_lo", avs_waitrequest, 32'h0);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("cont_waitreq_lo", avs_waitrequest, 32'h0);
    end
    step();
    chk("cont_waitreq_hi", avs_waitrequest, 32'h1);
    chk("cont_ready_lo", monitor_ready, 32'h0);
    step();
    chk("cont_waitreq_once", avs_waitrequest, 32'h0);
    step();
    chk("cont_ready", monitor_ready, 32'h1);
    chk("cont_data", MonDReg, 32'hFF00FF00);
    avs_read = 1'b0;
    step();

    // Busy: second write strobe one cycle after the first is dropped
    strobe_b(32'h11111111);
    strobe_b(32'h22222222);
    step();
    chk("busy_ready", monitor_ready, 32'h1);
    chk("busy_error", monitor_error, 32'h1);
    step(); step(); step();
    chk("busy_error_persist", monitor_error, 32'h1);
    strobe_a(9'h011, 1'b1);
    chk("busy_error_clr", monitor_error, 32'h0);
    step(); step();
    chk("busy_first_wr", MonDReg, 32'h11111111);
    strobe_na();
    step(); step();
    chk("busy_second_dropped", MonDReg, 32'h5A5A5A5A);

    // Reset while a write to 0x12 is pending
    strobe_b(32'h77777777);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_MonDReg", MonDReg, 32'h0);
    chk("rst_mid_ready", monitor_ready, 32'h0);
    chk("rst_mid_error", monitor_error, 32'h0);
    cpu_read_chk("rst_mid_wr_abandoned", 9'h012, 32'h5A5A5A5A);

    // Simultaneous ocimem_b + no_action_a: write wins at address 0, error flagged
    jdo = '0;
    jdo[34:3] = 32'h00C0FFEE;
    tk_b  = 1'b1;
    tk_na = 1'b1;
    step();
    tk_b  = 1'b0;
    tk_na = 1'b0;
    step(); step();
    chk("simul_ready", monitor_ready, 32'h1);
    chk("simul_error", monitor_error, 32'h1);
    cpu_read_chk("simul_wr_addr0", 9'h000, 32'h00C0FFEE);

`ifdef OCIMEM_PARITY_EN
    // Corrupt stored word 5 (data 0xF1, byte-0 parity 1) by clearing bit 0
    cpu_write(9'h005, 32'h000000F1, 4'hF);
    dut.mem_q[5][0] = 1'b0;
    strobe_a(9'h005, 1'b1);
    step(); step();
    chk("par_error", monitor_error, 32'h1);
    chk("par_data", MonDReg, 32'h000000F0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
